// File: rtl/execute_stage.sv
// execute_stage: EX stage with EX/MEM output register, single-cycle ALU and iterative MULTU/DIVU with HI/LO
module execute_stage #(
  parameter int MD_CYCLES = 32
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        InValid,
  input  logic [3:0]  ALUOp,
  input  logic [31:0] Operand1,
  input  logic [31:0] Operand2,
  input  logic [4:0]  Shamt,
  input  logic [31:0] StoreValueIn,
  input  logic        MemReadIn,
  input  logic        MemWriteIn,
  input  logic        RegWriteIn,
  input  logic [4:0]  DestRegIn,
  input  logic        Flush,
  output logic        Stall,
  output logic [31:0] ALUResult,
  output logic [31:0] StoreValue,
  output logic        EnableReadFromMemory,
  output logic        EnableWriteInMemory,
  output logic        RegWriteOut,
  output logic [4:0]  DestRegOut,
  output logic        OutValid,
  output logic        Zero
);
  localparam int CW = $clog2(MD_CYCLES);
  localparam logic [0:0] IDLE = 1'b0, BUSY = 1'b1;
  logic [0:0] state;
  logic [CW-1:0] counter;
  logic [31:0] hi, lo, md_a, alu, dsub;
  logic [63:0] md_p, md_nx;
  logic [32:0] msum, dsh;
  logic md_div, is_md, last, load, start, ge;
  always_comb begin
    alu = 32'd0;
    case (ALUOp)
      4'd0:  alu = Operand1 + Operand2;
      4'd1:  alu = Operand1 - Operand2;
      4'd2:  alu = Operand1 & Operand2;
      4'd3:  alu = Operand1 | Operand2;
      4'd4:  alu = Operand1 ^ Operand2;
      4'd5:  alu = ~(Operand1 | Operand2);
      4'd6:  alu = {31'd0, $signed(Operand1) < $signed(Operand2)};
      4'd7:  alu = {31'd0, Operand1 < Operand2};
      4'd8:  alu = Operand1 << Shamt;
      4'd9:  alu = Operand1 >> Shamt;
      4'd10: alu = $signed(Operand1) >>> Shamt;
      4'd13: alu = hi;
      4'd14: alu = lo;
      4'd15: alu = Operand2;
      default: alu = 32'd0;
    endcase
  end
  // md_p holds {acc, multiplier} for MULTU and {remainder, dividend/quotient} for DIVU
  assign msum  = {1'b0, md_p[63:32]} + (md_p[0] ? {1'b0, md_a} : 33'd0);
  assign dsh   = {md_p[63:32], md_p[31]};
  assign ge    = dsh >= {1'b0, md_a};
  assign dsub  = dsh[31:0] - md_a;
  assign md_nx = md_div ? {ge ? dsub : dsh[31:0], md_p[30:0], ge} : {msum, md_p[31:1]};
  assign is_md = ALUOp == 4'd11 || ALUOp == 4'd12;
  assign last  = state == BUSY && counter == CW'(MD_CYCLES - 1);
  assign Stall = Reset && !Flush && ((state == IDLE && InValid && is_md) || (state == BUSY && !last));
  assign load  = InValid && !Stall && !Flush && !is_md;
  assign start = state == IDLE && InValid && is_md && !Flush;
  always_ff @(posedge clk) begin
    if (!Reset) begin
      ALUResult <= '0;
      StoreValue <= '0;
      EnableReadFromMemory <= 1'b0;
      EnableWriteInMemory <= 1'b0;
      RegWriteOut <= 1'b0;
      DestRegOut <= '0;
      OutValid <= 1'b0;
      Zero <= 1'b0;
      hi <= '0;
      lo <= '0;
      state <= IDLE;
      counter <= '0;
      md_a <= '0;
      md_p <= '0;
      md_div <= 1'b0;
    end else begin
      ALUResult <= load ? alu : 32'd0;
      StoreValue <= load ? StoreValueIn : 32'd0;
      EnableReadFromMemory <= load && MemReadIn;
      EnableWriteInMemory <= load && MemWriteIn;
      RegWriteOut <= load && RegWriteIn;
      DestRegOut <= load ? DestRegIn : 5'd0;
      OutValid <= load;
      Zero <= load && alu == 32'd0;
      if (state == IDLE) begin
        if (start) begin
          state <= BUSY;
          counter <= '0;
          md_div <= ALUOp == 4'd12;
          md_a <= ALUOp == 4'd12 ? Operand2 : Operand1;
          md_p <= {32'd0, ALUOp == 4'd12 ? Operand1 : Operand2};
        end
      end else if (Flush) begin
        state <= IDLE;
        counter <= '0;
      end else begin
        md_p <= md_nx;
        counter <= counter + 1'b1;
        if (last) begin
          state <= IDLE;
          hi <= md_nx[63:32];
          lo <= md_nx[31:0];
        end
      end
    end
  end
endmodule
